// File: rtl/serial_multiplier_param.sv
// ---------------------------------------------------------------------------
// serial_multiplier_param
//
// Shift-and-add multiplier producing a 2*WIDTH-bit product from two WIDTH-bit
// operands, one bit of the multiplier per clock. Unsigned or two's-complement
// mode is chosen per operation. The operands and the mode are captured on the
// accepting edge. The result appears exactly WIDTH cycles later.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   SIGNED_EN  1: is_signed is honoured; 0: every operation is unsigned
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   Enable        in   start request, sampled only in IDLE or DONE
//   is_signed     in   1 = two's-complement operands (sampled with Enable)
//   multiplicant  in   operand M (sampled with Enable)
//   multiplier    in   operand Q (sampled with Enable)
//   product       out  result register, updated only on completion
//   busy          out  high while an operation runs
//   done          out  high from completion until next accepted start/reset
//   o_state       out  current FSM state (debug visibility)
//
// Handshake: a start is accepted on any rising edge where Enable=1 and busy=0
// (state IDLE or DONE). Enable while busy=1 is ignored and is not queued.
// ---------------------------------------------------------------------------
module serial_multiplier_param #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Enable,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicant,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH:0]    r_a;      // partial product, one guard bit
  logic [WIDTH-1:0]  r_q;      // multiplier bits, product low half shifts in
  logic [WIDTH-1:0]  r_m;      // latched multiplicand
  logic [CW-1:0]     r_count;
  logic              r_mode;   // 1 = signed operation

  logic              w_last;
  logic [WIDTH+1:0]  w_a_x;    // A extended by one bit to catch the carry/sign
  logic [WIDTH+1:0]  w_m_x;    // ext(M), widened to the same size
  logic [WIDTH+1:0]  w_sum;
  logic [WIDTH:0]    w_a_next;
  logic [WIDTH-1:0]  w_q_next;

  assign w_last = (r_count == LAST_CNT);

  // In signed mode both terms are sign-extended, so bit WIDTH+1 of the sum is
  // the true sign. In unsigned mode it is the carry-out. In either case it
  // is the bit that enters A's MSB on the right shift.
  assign w_a_x = {r_mode & r_a[WIDTH], r_a};
  assign w_m_x = {{2{r_mode & r_m[WIDTH-1]}}, r_m};

  always_comb begin
    w_sum = w_a_x;
    if (r_q[0]) begin
      // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement,
      // so the final iteration subtracts instead of adding.
      if (w_last && r_mode) w_sum = w_a_x - w_m_x;
      else                  w_sum = w_a_x + w_m_x;
    end
  end

  assign w_a_next = w_sum[WIDTH+1:1];
  assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

  assign o_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_mode  <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Enable) begin
            r_m     <= multiplicant;
            r_q     <= multiplier;
            r_mode  <= is_signed & SIGNED_EN;
            r_a     <= '0;
            r_count <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            product <= {w_a_next[WIDTH-1:0], w_q_next};
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_multiplier_param.sv
// ---------------------------------------------------------------------------
// Bench for serial_multiplier_param. It uses two instances: an 8-bit one with
// signed support, and a 4-bit one that is unsigned only. The driver tasks push
// the expected product and the expected completion edge into queues. Monitors
// pop them and compare when done rises.
// ---------------------------------------------------------------------------
module tb_serial_multiplier_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        en8, sg8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;
  logic        busy8, done8;
  logic [1:0]  st8;

  logic        en4, sg4;
  logic [3:0]  m4, q4;
  logic [7:0]  p4;
  logic        busy4, done4;
  logic [1:0]  st4;

  serial_multiplier_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .Enable(en8), .is_signed(sg8),
    .multiplicant(m8), .multiplier(q8), .product(p8),
    .busy(busy8), .done(done8), .o_state(st8)
  );

  serial_multiplier_param #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4 (
    .clk(clk), .reset(reset), .Enable(en4), .is_signed(sg4),
    .multiplicant(m4), .multiplier(q4), .product(p4),
    .busy(busy4), .done(done4), .o_state(st4)
  );

  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp8_q[$];
  int          edge8_q[$];
  logic [7:0]  exp4_q[$];
  int          edge4_q[$];

  // Reference model: plain integer multiplication of the operands.
  function automatic logic [15:0] ref_mul8(logic [7:0] m, logic [7:0] q, bit s);
    int a, b;
    if (s) begin
      a = int'($signed(m));
      b = int'($signed(q));
    end else begin
      a = int'(m);
      b = int'(q);
    end
    return 16'(a * b);
  endfunction

  function automatic logic [7:0] ref_mul4(logic [3:0] m, logic [3:0] q);
    return 8'(int'(m) * int'(q));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  // ---------------- monitors ----------------
  int   brun8 = 0;
  logic pdone8 = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    int          ee;
    if (reset) begin
      brun8  = 0;
      pdone8 = done8;
    end else begin
      if (busy8) brun8++;
      if (done8 && !pdone8) begin
        if (exp8_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected8: done rose with nothing expected, product %0h", p8);
        end else begin
          e  = exp8_q.pop_front();
          ee = edge8_q.pop_front();
          check("prod8", 32'(p8), 32'(e));
          check("latency8", n_edge, ee);
          check("busy_len8", brun8, 8);
        end
      end
      if (!busy8) brun8 = 0;
      pdone8 = done8;
    end
  end

  logic pdone4 = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e;
    int         ee;
    if (reset) begin
      pdone4 = done4;
    end else begin
      if (done4 && !pdone4) begin
        if (exp4_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected4: done rose with nothing expected, product %0h", p4);
        end else begin
          e  = exp4_q.pop_front();
          ee = edge4_q.pop_front();
          check("prod4", 32'(p4), 32'(e));
          check("latency4", n_edge, ee);
        end
      end
      pdone4 = done4;
    end
  end

  // ---------------- drivers ----------------
  // Call these just after a rising edge, while the DUT is idle or done.
  task automatic start8(logic [7:0] m, logic [7:0] q, bit s);
    m8 = m; q8 = q; sg8 = s; en8 = 1'b1;
    exp8_q.push_back(ref_mul8(m, q, s));
    edge8_q.push_back(n_edge + 1 + 8);
    @(posedge clk); #1;
    en8 = 1'b0;
    m8  = 8'($urandom);
    q8  = 8'($urandom);
    sg8 = 1'($urandom_range(0, 1));
  endtask

  task automatic wait8(int budget);
    int k = 0;
    while (exp8_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp8_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout8: %0d results outstanding after %0d cycles", exp8_q.size(), budget);
      exp8_q.delete();
      edge8_q.delete();
    end
  endtask

  task automatic start4(logic [3:0] m, logic [3:0] q);
    m4 = m; q4 = q; sg4 = 1'b1; en4 = 1'b1;
    exp4_q.push_back(ref_mul4(m, q));
    edge4_q.push_back(n_edge + 1 + 4);
    @(posedge clk); #1;
    en4 = 1'b0;
    m4  = 4'($urandom);
    q4  = 4'($urandom);
  endtask

  task automatic wait4(int budget);
    int k = 0;
    while (exp4_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp4_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout4: %0d results outstanding after %0d cycles", exp4_q.size(), budget);
      exp4_q.delete();
      edge4_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bm [3];
    logic [7:0] bq [3];
    bit         bs [3];

    reset = 1'b1;
    en8 = 1'b0; sg8 = 1'b0; m8 = '0; q8 = '0;
    en4 = 1'b0; sg4 = 1'b0; m4 = '0; q4 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_prod8", 32'(p8), 32'h0);
    check("rst_busy8", 32'(busy8), 32'h0);
    check("rst_done8", 32'(done8), 32'h0);
    check("rst_prod4", 32'(p4), 32'h0);
    check("rst_busy4", 32'(busy4), 32'h0);
    check("rst_done4", 32'(done4), 32'h0);

    // Largest unsigned operands.
    start8(8'hFF, 8'hFF, 1'b0);
    wait8(20);

    // Signed corner cases.
    start8(8'h80, 8'h80, 1'b1); wait8(20);
    start8(8'hFF, 8'h7F, 1'b1); wait8(20);
    start8(8'hFB, 8'h03, 1'b1); wait8(20);
    start8(8'h00, 8'h80, 1'b1); wait8(20);
    start8(8'h80, 8'h7F, 1'b0); wait8(20);

    // Random operands and mode.
    for (int i = 0; i < 30; i++) begin
      start8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      wait8(20);
    end

    // Operand changes and a second Enable during RUN are ignored.
    start8(8'd3, 8'd4, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    m8 = 8'd9; q8 = 8'd9; en8 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    en8 = 1'b0;
    wait8(20);
    repeat (2) begin @(posedge clk); #1; end
    check("done_hold", 32'(done8), 32'h1);
    check("prod_hold", 32'(p8), 32'd12);
    check("busy_hold", 32'(busy8), 32'h0);

    // Back-to-back with Enable held high.
    for (int i = 0; i < 3; i++) begin
      bm[i] = 8'($urandom);
      bq[i] = 8'($urandom);
      bs[i] = 1'($urandom_range(0, 1));
    end
    m8 = bm[0]; q8 = bq[0]; sg8 = bs[0]; en8 = 1'b1;
    exp8_q.push_back(ref_mul8(bm[0], bq[0], bs[0]));
    edge8_q.push_back(n_edge + 1 + 8);
    @(posedge clk); #1;
    for (int i = 1; i < 3; i++) begin
      m8 = bm[i]; q8 = bq[i]; sg8 = bs[i];
      exp8_q.push_back(ref_mul8(bm[i], bq[i], bs[i]));
      edge8_q.push_back(n_edge + 17);
      repeat (9) begin @(posedge clk); #1; end
      check("b2b_gap_done", 32'(done8), 32'h0);
      check("b2b_gap_busy", 32'(busy8), 32'h1);
    end
    en8 = 1'b0;
    wait8(30);

    // Reset on the fourth RUN iteration discards the operation.
    start8(8'h55, 8'h33, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp8_q.delete();
    edge8_q.delete();
    check("midrst_busy", 32'(busy8), 32'h0);
    check("midrst_done", 32'(done8), 32'h0);
    check("midrst_prod", 32'(p8), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_idle_busy", 32'(busy8), 32'h0);
    check("midrst_idle_done", 32'(done8), 32'h0);
    start8(8'd7, 8'd6, 1'b0);
    wait8(20);

    // Unsigned-only 4-bit instance; is_signed is held high and must not matter.
    start4(4'hF, 4'hF);
    wait4(12);
    start4(4'h8, 4'hF);
    wait4(12);
    for (int i = 0; i < 50; i++) begin
      start4(4'($urandom), 4'($urandom));
      wait4(12);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
